fp_align_prep: RTL and testbench

Exponent-compare and operand-swap stage for the single-precision add/subtract path. Sits directly upstream of the 23-bit pipelined right barrel shifter. It picks the larger operand, computes the saturated exponent difference, and presents the shift amount one cycle ahead of the smaller mantissa, matching the shifter's registered-select input. The larger operand's fields go through a delay line so they leave the block aligned with the shifter's output.

---
 rtl/fp_align_pkg.sv | 24 ++
 rtl/fp_delay_line.sv | 25 ++
 rtl/fp_align_prep.sv | 118 +++++++++++
 tb/tb_fp_align_prep.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared widths, constants and the sideband bundle for the FP add/sub alignment stage.
// The sticky field exists only when FP_ALIGN_STICKY_EN is defined.
package fp_align_pkg;

    localparam int unsigned EXP_W         = 8;
    localparam int unsigned MAN_W         = 23;
    localparam int unsigned SHAMT_W       = 5;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
    localparam int unsigned SHAMT_MAX     = 31;
    localparam int unsigned SHIFT_LAT_DEF = 5;

    typedef struct packed {
        logic             valid;
        logic             big_sign;
        logic [EXP_W-1:0] big_exp;
        logic [MAN_W-1:0] big_man;
        logic             eff_sub;
        logic             special;
`ifdef FP_ALIGN_STICKY_EN
        logic             sticky;
`endif
    } sideband_t;

endpackage

// File: rtl/fp_delay_line.sv
// Fixed-depth register chain with async active-low reset; carries the sideband bundle.
module fp_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fp_align_prep.sv
// Exponent compare / operand swap ahead of the pipelined right shifter.
// Optional sticky output is enabled by defining FP_ALIGN_STICKY_EN.
module fp_align_prep
    import fp_align_pkg::*;
#(
    parameter int unsigned SHIFT_LAT = SHIFT_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    input  logic               op_sub,
    output logic [SHAMT_W-1:0] shift_amt,
    output logic [MAN_W-1:0]   small_man,
    output logic               out_valid,
    output logic               big_sign,
    output logic [EXP_W-1:0]   big_exp,
    output logic [MAN_W-1:0]   big_man,
    output logic               eff_sub,
    output logic               special
`ifdef FP_ALIGN_STICKY_EN
    ,
    output logic               sticky
`endif
);

    logic [31:0] a_q, b_q;
    logic        sub_q, vld_q;

    // Stage A: unconditional input capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= in_a;
            b_q   <= in_b;
            sub_q <= op_sub;
            vld_q <= in_valid;
        end
    end

    logic               a_big, b_sign_eff, small_zero;
    logic [EXP_W-1:0]   exp_big, exp_small, diff;
    logic [MAN_W-1:0]   man_big, man_small;
    logic [SHAMT_W-1:0] shamt_c;
    sideband_t          sb_c;

    // Stage B: magnitude compare, swap, saturated shift amount
    always_comb begin
        a_big      = a_q[30:0] >= b_q[30:0];
        b_sign_eff = b_q[31] ^ sub_q;
        exp_big    = a_big ? a_q[30:23] : b_q[30:23];
        exp_small  = a_big ? b_q[30:23] : a_q[30:23];
        man_big    = a_big ? a_q[22:0]  : b_q[22:0];
        man_small  = a_big ? b_q[22:0]  : a_q[22:0];
        diff       = exp_big - exp_small;
        small_zero = (exp_small == '0);
        if (small_zero || (diff > EXP_W'(SHAMT_MAX))) shamt_c = SHAMT_W'(SHAMT_MAX);
        else                                          shamt_c = diff[SHAMT_W-1:0];

        sb_c          = '0;
        sb_c.valid    = vld_q;
        sb_c.big_sign = a_big ? a_q[31] : b_sign_eff;
        sb_c.big_exp  = exp_big;
        sb_c.big_man  = man_big;
        sb_c.eff_sub  = a_q[31] ^ b_sign_eff;
        sb_c.special  = (a_q[30:23] == EXP_SPECIAL) || (b_q[30:23] == EXP_SPECIAL);
`ifdef FP_ALIGN_STICKY_EN
        // Bits of {1, man_small} that fall off the bottom of the shifter
        if (small_zero)                sb_c.sticky = 1'b0;
        else if (shamt_c >= 5'd24)     sb_c.sticky = 1'b1;
        else sb_c.sticky = |({1'b1, man_small} & ((24'(1) << shamt_c) - 24'(1)));
`endif
    end

    logic [MAN_W-1:0] small_man_b;
    sideband_t        sb_q, sb_out;

    // Stage B register plus Stage C mantissa, one cycle behind the shift amount
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_amt   <= '0;
            small_man_b <= '0;
            small_man   <= '0;
            sb_q        <= '0;
        end else begin
            shift_amt   <= shamt_c;
            small_man_b <= man_small;
            small_man   <= small_man_b;
            sb_q        <= sb_c;
        end
    end

    fp_delay_line #(
        .WIDTH ($bits(sideband_t)),
        .DEPTH (SHIFT_LAT)
    ) u_sb_dly (
        .clk   (clk),
        .reset (reset),
        .d     (sb_q),
        .q     (sb_out)
    );

    assign out_valid = sb_out.valid;
    assign big_sign  = sb_out.big_sign;
    assign big_exp   = sb_out.big_exp;
    assign big_man   = sb_out.big_man;
    assign eff_sub   = sb_out.eff_sub;
    assign special   = sb_out.special;
`ifdef FP_ALIGN_STICKY_EN
    assign sticky    = sb_out.sticky;
`endif

endmodule

// File: tb/tb_fp_align_prep.sv
// Directed self-checking bench for fp_align_prep (default SHIFT_LAT = 5).
module tb_fp_align_prep;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        op_sub;
    logic [4:0]  shift_amt;
    logic [22:0] small_man, big_man;
    logic        out_valid, big_sign, eff_sub, special;
    logic [7:0]  big_exp;
`ifdef FP_ALIGN_STICKY_EN
    logic        sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_align_prep dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .op_sub    (op_sub),
        .shift_amt (shift_amt),
        .small_man (small_man),
        .out_valid (out_valid),
        .big_sign  (big_sign),
        .big_exp   (big_exp),
        .big_man   (big_man),
        .eff_sub   (eff_sub),
        .special   (special)
`ifdef FP_ALIGN_STICKY_EN
        ,
        .sticky    (sticky)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_shamt"}, 32'(shift_amt), 32'd0);
        chk({tag, "_sman"},  32'(small_man), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_side"},  {8'd0, big_sign, big_exp, big_man} | 32'({eff_sub, special}), 32'd0);
    endtask

    // One isolated operation: inputs sampled at edge k, checks at k+1, k+2, k+6, k+7
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [4:0] e_sh, input logic [22:0] e_sm,
                          input logic e_sign, input logic [7:0] e_exp, input logic [22:0] e_man,
                          input logic e_eff, input logic e_spec, input logic e_stk);
        in_a = a; in_b = b; op_sub = sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_shamt"}, 32'(shift_amt), 32'(e_sh));
        tick();
        chk({tag, "_sman"}, 32'(small_man), 32'(e_sm));
        repeat (3) tick();
        chk({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"},   32'(out_valid), 32'd1);
        chk({tag, "_sign"},    32'(big_sign),  32'(e_sign));
        chk({tag, "_exp"},     32'(big_exp),   32'(e_exp));
        chk({tag, "_man"},     32'(big_man),   32'(e_man));
        chk({tag, "_effsub"},  32'(eff_sub),   32'(e_eff));
        chk({tag, "_special"}, 32'(special),   32'(e_spec));
`ifdef FP_ALIGN_STICKY_EN
        chk({tag, "_sticky"},  32'(sticky),    32'(e_stk));
`else
        if (e_stk === 1'bx) $display("unused sticky expectation");
`endif
        tick();
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; op_sub = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        repeat (2) tick();

        //      tag    a             b             sub  sh     sman        sg   exp     man         eff  spc  stk
        run_op("abig", 32'h40400000, 32'h3F800000, 0, 5'd1,  23'h000000, 0, 8'h80, 23'h400000, 0, 0, 0);
        run_op("swap", 32'h3F800000, 32'h40400000, 1, 5'd1,  23'h000000, 1, 8'h80, 23'h400000, 1, 0, 0);
        run_op("tie",  32'h40000000, 32'h40000000, 1, 5'd0,  23'h000000, 0, 8'h80, 23'h000000, 1, 0, 0);
        run_op("neg",  32'hC0A00000, 32'h40400000, 0, 5'd1,  23'h400000, 1, 8'h81, 23'h200000, 1, 0, 0);
        run_op("sat",  32'h7F000000, 32'h3F800000, 0, 5'd31, 23'h000000, 0, 8'hFE, 23'h000000, 0, 0, 1);
        run_op("zero", 32'h3F800000, 32'h00000000, 0, 5'd31, 23'h000000, 0, 8'h7F, 23'h000000, 0, 0, 0);
        run_op("spec", 32'h7F800000, 32'h3F800000, 0, 5'd31, 23'h000000, 0, 8'hFF, 23'h000000, 0, 1, 1);
        run_op("stky", 32'h4B000000, 32'h3F800001, 0, 5'd23, 23'h000001, 0, 8'h96, 23'h000000, 0, 0, 1);

        // Ten back-to-back operations; item i: exp 130+i, man i, vs 1.0 -> shift 3+i
        for (int c = 0; c < 20; c++) begin
            if (c < 10) begin
                in_a = {1'b0, 8'(130 + c), 23'(c)}; in_b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 10) chk($sformatf("strm_shamt%0d", c), 32'(shift_amt), 32'(3 + c - 1));
            chk($sformatf("strm_valid%0d", c), 32'(out_valid), (c >= 6 && c < 16) ? 32'd1 : 32'd0);
            if (c >= 6 && c < 16) begin
                chk($sformatf("strm_exp%0d", c), 32'(big_exp), 32'(130 + c - 6));
                chk($sformatf("strm_man%0d", c), 32'(big_man), 32'(c - 6));
            end
        end

        // Mid-stream asynchronous reset, then confirm nothing stale emerges
        for (int c = 0; c < 8; c++) begin
            in_a = {1'b0, 8'(140 + c), 23'h1234}; in_b = 32'h40000000; op_sub = 1'b1; in_valid = 1'b1;
            tick();
        end
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("rst_async");
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("rst_stale%0d", c), 32'(out_valid), 32'd0);
        end
        run_op("post", 32'h40400000, 32'h3F800000, 0, 5'd1, 23'h000000, 0, 8'h80, 23'h400000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
